// File: rtl/crc_stream_engine.sv
// Streaming CRC generator/checker: DATA_W message bits per accepted beat, MSB first,
// with a one-cycle result strobe. Defaults give CRC24A.
module crc_stream_engine #(
    parameter int                 CRC_W   = 24,
    parameter logic [CRC_W-1:0]   POLY    = 24'h864CFB,
    parameter int                 DATA_W  = 8,
    parameter logic [CRC_W-1:0]   INIT    = '0,
    parameter logic [CRC_W-1:0]   XOR_OUT = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              mode,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_last,
    output logic [CRC_W-1:0]  crc_out,
    output logic              crc_valid,
    output logic              crc_ok,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_reg, state_next;
    logic [CRC_W-1:0]   crc_reg, crc_next;
    logic [CRC_W-1:0]   crc_out_reg, crc_out_next;
    logic               crc_ok_reg, crc_ok_next;
    logic               mode_reg, mode_next;
    logic [CRC_W-1:0]   seed;
    logic [CRC_W-1:0]   stepped;
    logic               eff_mode;
    logic               accept;

    // DATA_W serial LFSR steps unrolled; feeding the bit in at the top makes the
    // result equal to division of the zero-augmented message, so no padding is needed.
    function automatic logic [CRC_W-1:0] crc_step(input logic [CRC_W-1:0] c,
                                                  input logic [DATA_W-1:0] d);
        logic [CRC_W-1:0] r;
        logic             fb;
        r = c;
        for (int i = DATA_W - 1; i >= 0; i--) begin
            fb = r[CRC_W-1] ^ d[i];
            r  = {r[CRC_W-2:0], 1'b0} ^ (fb ? POLY : '0);
        end
        return r;
    endfunction

    assign s_ready   = (state_reg != DONE);
    assign accept    = s_valid && s_ready;
    assign crc_valid = (state_reg == DONE);
    assign busy      = (state_reg == RUN);
    assign crc_out   = crc_out_reg;
    assign crc_ok    = crc_ok_reg;

    // A message starting in IDLE uses the fresh seed and the live mode input.
    assign seed     = (state_reg == IDLE) ? INIT : crc_reg;
    assign eff_mode = (state_reg == IDLE) ? mode : mode_reg;
    assign stepped  = crc_step(seed, s_data);

    always_comb begin
        state_next   = state_reg;
        crc_next     = crc_reg;
        crc_out_next = crc_out_reg;
        crc_ok_next  = crc_ok_reg;
        mode_next    = mode_reg;
        case (state_reg)
            IDLE, RUN: begin
                if (accept) begin
                    crc_next  = stepped;
                    mode_next = eff_mode;
                    if (s_last) begin
                        state_next   = DONE;
                        crc_out_next = stepped ^ XOR_OUT;
                        crc_ok_next  = eff_mode && (stepped == '0);
                    end else begin
                        state_next = RUN;
                    end
                end
            end
            DONE: begin
                state_next = IDLE;
                crc_next   = INIT;
            end
            default: begin
                state_next = IDLE;
                crc_next   = INIT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg   <= IDLE;
            crc_reg     <= INIT;
            crc_out_reg <= '0;
            crc_ok_reg  <= 1'b0;
            mode_reg    <= 1'b0;
        end else begin
            state_reg   <= state_next;
            crc_reg     <= crc_next;
            crc_out_reg <= crc_out_next;
            crc_ok_reg  <= crc_ok_next;
            mode_reg    <= mode_next;
        end
    end

endmodule
